// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, base addresses and command types for the
// rectangle writer and the line-buffer display reader.
package fb_pkg;

    localparam logic [21:0] FB_ADDR1          = 22'h100000;
    localparam logic [21:0] FB_ADDR2          = 22'h200000;
    localparam int unsigned FB_WORDS_PER_LINE = 40;
    localparam int unsigned FB_LINES          = 480;

    typedef enum logic [2:0] {
        IDLE,
        CLIP,
        WAIT_BUS,
        WRITE,
        DONE
    } fb_state_t;

    typedef struct packed {
        logic [5:0] xw;
        logic [8:0] y;
        logic [5:0] w;
        logic [8:0] h;
        logic [7:0] color;
    } fb_cmd_t;

endpackage

// File: rtl/fb_rect_writer.sv
// Rectangle fill engine: clips one command to the 640x480 back buffer and
// writes replicated-colour words, yielding the SDRAM port to the reader.
module fb_rect_writer
    import fb_pkg::*;
#(
    parameter logic [21:0] ADDR1          = FB_ADDR1,
    parameter logic [21:0] ADDR2          = FB_ADDR2,
    parameter int unsigned WORDS_PER_LINE = FB_WORDS_PER_LINE,
    parameter int unsigned LINES          = FB_LINES
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [5:0]   cmd_xw,
    input  logic [8:0]   cmd_y,
    input  logic [5:0]   cmd_w,
    input  logic [8:0]   cmd_h,
    input  logic [7:0]   cmd_color,
    input  logic         frame_flip,
    input  logic         reader_busy,
    output logic         sdram_wr,
    output logic [21:0]  sdram_addr,
    output logic [127:0] sdram_wdata,
    input  logic         sdram_ac,
    output logic         busy,
    output logic         done
);

    fb_state_t   r_state;
    fb_state_t   w_next;
    fb_cmd_t     r_cmd;
    logic [21:0] r_base;
    logic [5:0]  r_col;
    logic [5:0]  r_col_last;
    logic [8:0]  r_row;
    logic [8:0]  r_row_last;

    logic        w_in_range;
    logic [6:0]  w_wrem;
    logic [9:0]  w_hrem;
    logic [6:0]  w_weff;
    logic [9:0]  w_heff;
    logic        w_empty;
    logic [5:0]  w_col_last;
    logic [8:0]  w_row_last;
    logic        w_last_col;
    logic        w_last_word;
    logic [14:0] w_row_off;
    logic [21:0] w_addr;

    // Clipping: remaining room is only meaningful when the origin is on screen.
    assign w_in_range = (32'(r_cmd.xw) < WORDS_PER_LINE) && (32'(r_cmd.y) < LINES);
    assign w_wrem     = 7'(WORDS_PER_LINE) - {1'b0, r_cmd.xw};
    assign w_hrem     = 10'(LINES) - {1'b0, r_cmd.y};
    assign w_weff     = !w_in_range ? '0 :
                        (({1'b0, r_cmd.w} < w_wrem) ? {1'b0, r_cmd.w} : w_wrem);
    assign w_heff     = !w_in_range ? '0 :
                        (({1'b0, r_cmd.h} < w_hrem) ? {1'b0, r_cmd.h} : w_hrem);
    assign w_empty    = (w_weff == '0) || (w_heff == '0);
    assign w_col_last = r_cmd.xw + w_weff[5:0] - 6'd1;
    assign w_row_last = r_cmd.y + w_heff[8:0] - 9'd1;

    assign w_last_col  = (r_col == r_col_last);
    assign w_last_word = w_last_col && (r_row == r_row_last);

    assign w_row_off = 15'(r_row) * 15'(WORDS_PER_LINE);
    assign w_addr    = r_base + 22'(w_row_off) + 22'(r_col);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        sdram_wr    = 1'b0;
        sdram_addr  = '0;
        sdram_wdata = '0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_next = CLIP;
                end
            end
            CLIP: begin
                w_next = w_empty ? DONE : WAIT_BUS;
            end
            WAIT_BUS: begin
                if (!reader_busy) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                sdram_wr    = 1'b1;
                sdram_addr  = w_addr;
                sdram_wdata = {16{r_cmd.color}};
                if (sdram_ac) begin
                    w_next = w_last_word ? DONE : WAIT_BUS;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cmd      <= '0;
            r_base     <= '0;
            r_col      <= '0;
            r_col_last <= '0;
            r_row      <= '0;
            r_row_last <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_cmd  <= '{xw: cmd_xw, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
                        r_base <= frame_flip ? ADDR2 : ADDR1;
                    end
                end
                CLIP: begin
                    r_col      <= r_cmd.xw;
                    r_row      <= r_cmd.y;
                    r_col_last <= w_col_last;
                    r_row_last <= w_row_last;
                end
                WRITE: begin
                    if (sdram_ac && !w_last_word) begin
                        if (w_last_col) begin
                            r_col <= r_cmd.xw;
                            r_row <= r_row + 9'd1;
                        end else begin
                            r_col <= r_col + 6'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
